// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and types for the memory access stage
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    localparam logic [7:0] STRB_BASE_B = 8'h01;
    localparam logic [7:0] STRB_BASE_H = 8'h03;
    localparam logic [7:0] STRB_BASE_W = 8'h0F;
    localparam logic [7:0] STRB_BASE_D = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    // Byte-enable pattern for an access at lane 0; funct3[1:0] encodes log2(bytes).
    function automatic logic [7:0] strb_base(input logic [1:0] size);
        case (size)
            2'd0:    strb_base = STRB_BASE_B;
            2'd1:    strb_base = STRB_BASE_H;
            2'd2:    strb_base = STRB_BASE_W;
            default: strb_base = STRB_BASE_D;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - lane-select, truncate and extend doubleword load data
module load_extend
    import mem_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  off,
    input  logic [2:0]  funct3,
    output logic [63:0] ext
);

    logic [63:0] shifted;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        ext     = shifted;
        case (funct3)
            F3_LB:   ext = {{56{shifted[7]}},  shifted[7:0]};
            F3_LH:   ext = {{48{shifted[15]}}, shifted[15:0]};
            F3_LW:   ext = {{32{shifted[31]}}, shifted[31:0]};
            F3_LD:   ext = shifted;
            F3_LBU:  ext = {56'd0, shifted[7:0]};
            F3_LHU:  ext = {48'd0, shifted[15:0]};
            F3_LWU:  ext = {32'd0, shifted[31:0]};
            default: ext = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV64 load/store stage over a req/ack data bus
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              reg_write_in,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rd_in,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   store_data,
    output logic              stall,
    output logic              valid_out,
    output logic [XLEN-1:0]   wb_data,
    output logic [4:0]        rd_out,
    output logic              reg_write_out,
    output logic              mem_fault,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [STRB_W-1:0] dmem_wstrb,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_ack
);

    state_t state_q, state_d;

    logic              cap_we_q,    cap_we_d;
    logic              cap_regw_q,  cap_regw_d;
    logic [2:0]        cap_f3_q,    cap_f3_d;
    logic [2:0]        cap_off_q,   cap_off_d;
    logic [4:0]        cap_rd_q,    cap_rd_d;
    logic [XLEN-1:0]   cap_addr_q,  cap_addr_d;
    logic [XLEN-1:0]   cap_wdata_q, cap_wdata_d;
    logic [STRB_W-1:0] cap_wstrb_q, cap_wstrb_d;

    logic              valid_q,  valid_d;
    logic              fault_q,  fault_d;
    logic [XLEN-1:0]   wb_q,     wb_d;
    logic [4:0]        rd_q,     rd_d;
    logic              regw_q,   regw_d;

    logic [2:0]        off;
    logic              misaligned;
    logic              f3_ok;
    logic              is_mem;
    logic              mem_ok;
    logic              fault;
    logic [XLEN-1:0]   load_ext;

    assign off    = alu_result[2:0];
    assign is_mem = mem_read ^ mem_write;

    always_comb begin
        misaligned = 1'b0;
        case (funct3[1:0])
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = off[0];
            2'd2:    misaligned = |off[1:0];
            default: misaligned = |off;
        endcase
    end

    always_comb begin
        f3_ok = 1'b0;
        if (mem_read) begin
            f3_ok = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LD, F3_LBU, F3_LHU, F3_LWU};
        end else begin
            f3_ok = funct3 inside {F3_SB, F3_SH, F3_SW, F3_SD};
        end
    end

    // Both read and write set, or a single access that fails decode, is answered as a fault.
    assign mem_ok = is_mem & f3_ok & ~misaligned;
    assign fault  = (mem_read & mem_write) | (is_mem & ~mem_ok);

    load_extend u_load_extend (
        .rdata  (dmem_rdata),
        .off    (cap_off_q),
        .funct3 (cap_f3_q),
        .ext    (load_ext)
    );

    always_comb begin
        state_d     = state_q;
        cap_we_d    = cap_we_q;
        cap_regw_d  = cap_regw_q;
        cap_f3_d    = cap_f3_q;
        cap_off_d   = cap_off_q;
        cap_rd_d    = cap_rd_q;
        cap_addr_d  = cap_addr_q;
        cap_wdata_d = cap_wdata_q;
        cap_wstrb_d = cap_wstrb_q;
        valid_d     = 1'b0;
        fault_d     = 1'b0;
        wb_d        = wb_q;
        rd_d        = rd_q;
        regw_d      = regw_q;
        stall       = 1'b0;

        case (state_q)
            ACCESS: begin
                stall = ~dmem_ack;
                if (dmem_ack) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    rd_d    = cap_rd_q;
                    if (cap_we_q) begin
                        wb_d   = '0;
                        regw_d = 1'b0;
                    end else begin
                        wb_d   = load_ext;
                        regw_d = cap_regw_q;
                    end
                end
            end
            default: begin
                // DONE behaves as IDLE so a new instruction can issue back-to-back.
                state_d = IDLE;
                if (valid_in) begin
                    if (mem_ok) begin
                        stall       = 1'b1;
                        state_d     = ACCESS;
                        cap_we_d    = mem_write;
                        cap_regw_d  = reg_write_in;
                        cap_f3_d    = funct3;
                        cap_off_d   = off;
                        cap_rd_d    = rd_in;
                        cap_addr_d  = {alu_result[XLEN-1:3], 3'b000};
                        cap_wdata_d = store_data << {off, 3'b000};
                        cap_wstrb_d = mem_write ? (strb_base(funct3[1:0]) << off) : '0;
                    end else begin
                        valid_d = 1'b1;
                        fault_d = fault;
                        wb_d    = alu_result;
                        rd_d    = rd_in;
                        regw_d  = reg_write_in & ~fault;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cap_we_q    <= 1'b0;
            cap_regw_q  <= 1'b0;
            cap_f3_q    <= '0;
            cap_off_q   <= '0;
            cap_rd_q    <= '0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            cap_wstrb_q <= '0;
            valid_q     <= 1'b0;
            fault_q     <= 1'b0;
            wb_q        <= '0;
            rd_q        <= '0;
            regw_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_we_q    <= cap_we_d;
            cap_regw_q  <= cap_regw_d;
            cap_f3_q    <= cap_f3_d;
            cap_off_q   <= cap_off_d;
            cap_rd_q    <= cap_rd_d;
            cap_addr_q  <= cap_addr_d;
            cap_wdata_q <= cap_wdata_d;
            cap_wstrb_q <= cap_wstrb_d;
            valid_q     <= valid_d;
            fault_q     <= fault_d;
            wb_q        <= wb_d;
            rd_q        <= rd_d;
            regw_q      <= regw_d;
        end
    end

    assign dmem_req      = (state_q == ACCESS);
    assign dmem_we       = cap_we_q;
    assign dmem_addr     = cap_addr_q;
    assign dmem_wdata    = cap_wdata_q;
    assign dmem_wstrb    = cap_wstrb_q;
    assign valid_out     = valid_q;
    assign mem_fault     = fault_q;
    assign wb_data       = wb_q;
    assign rd_out        = rd_q;
    assign reg_write_out = regw_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized self-checking bench for mem_access_stage
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, mem_read, mem_write, reg_write_in;
    logic [2:0]  funct3;
    logic [4:0]  rd_in;
    logic [63:0] alu_result, store_data;
    logic        stall, valid_out, reg_write_out, mem_fault;
    logic [63:0] wb_data;
    logic [4:0]  rd_out;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0]  dmem_wstrb;

    int n_cmp = 0;
    int n_err = 0;

    logic        exp_valid, exp_fault, exp_regw;
    logic [63:0] exp_wb;
    logic [4:0]  exp_rd;

    mem_access_stage dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write_in  (reg_write_in),
        .funct3        (funct3),
        .rd_in         (rd_in),
        .alu_result    (alu_result),
        .store_data    (store_data),
        .stall         (stall),
        .valid_out     (valid_out),
        .wb_data       (wb_data),
        .rd_out        (rd_out),
        .reg_write_out (reg_write_out),
        .mem_fault     (mem_fault),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_wstrb    (dmem_wstrb),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outs();
        chk("valid_out", {63'd0, valid_out}, {63'd0, exp_valid});
        chk("mem_fault", {63'd0, mem_fault}, {63'd0, exp_fault});
        chk("wb_data", wb_data, exp_wb);
        chk("reg_write_out", {63'd0, reg_write_out}, {63'd0, exp_regw});
        chk("rd_out", {59'd0, rd_out}, {59'd0, exp_rd});
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] rdata, input logic [2:0] f3,
                                             input int off);
        int nb;
        logic [63:0] v, m;
        nb = 1 << f3[1:0];
        v  = rdata >> (8 * off);
        m  = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        v  = v & m;
        if (!f3[2] && nb < 8 && v[8*nb-1]) v = v | ~m;
        return v;
    endfunction

    // Presents one instruction in an IDLE/DONE cycle; the memory acks after dly extra cycles.
    task automatic do_op(input logic vin, input logic rdq, input logic wrq, input logic regw,
                         input logic [2:0] f3, input logic [4:0] rd, input logic [63:0] alu,
                         input logic [63:0] sd, input int dly, input logic [63:0] rdata,
                         input logic spur);
        int nb;
        int off;
        logic legal;
        logic [63:0] exp_wdata;
        logic [7:0] exp_strb;
        nb  = 1 << f3[1:0];
        off = int'(alu[2:0]);
        legal = (rdq ^ wrq) && (rdq ? (f3 != 3'd7) : (f3 < 3'd4)) && ((alu % nb) == 0);
        valid_in = vin; mem_read = rdq; mem_write = wrq; reg_write_in = regw;
        funct3 = f3; rd_in = rd; alu_result = alu; store_data = sd;
        dmem_ack = spur; dmem_rdata = {$urandom, $urandom};
        @(negedge clk);
        check_outs();
        chk("stall_issue", {63'd0, stall}, {63'd0, vin && legal});
        chk("req_issue", {63'd0, dmem_req}, 64'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        if (!vin) begin
            exp_valid = 1'b0; exp_fault = 1'b0;
        end else if (!legal) begin
            exp_valid = 1'b1; exp_fault = rdq | wrq; exp_wb = alu;
            exp_regw = regw && !(rdq | wrq); exp_rd = rd;
        end else begin
            exp_valid = 1'b0; exp_fault = 1'b0;
            exp_wdata = sd << (8 * off);
            exp_strb  = wrq ? (8'((1 << nb) - 1) << off) : 8'd0;
            for (int k = 0; k <= dly; k++) begin
                dmem_ack   = (k == dly);
                dmem_rdata = (k == dly) ? rdata : {$urandom, $urandom};
                @(negedge clk);
                check_outs();
                chk("req", {63'd0, dmem_req}, 64'd1);
                chk("we", {63'd0, dmem_we}, {63'd0, wrq});
                chk("addr", dmem_addr, alu & ~64'd7);
                chk("wstrb", {56'd0, dmem_wstrb}, {56'd0, exp_strb});
                if (wrq) chk("wdata", dmem_wdata, exp_wdata);
                chk("stall_access", {63'd0, stall}, {63'd0, k != dly});
                @(posedge clk); #1;
            end
            dmem_ack = 1'b0;
            exp_valid = 1'b1; exp_rd = rd;
            exp_wb   = wrq ? 64'd0 : ref_load(rdata, f3, off);
            exp_regw = wrq ? 1'b0 : regw;
        end
    endtask

    task automatic reset_mid_access();
        valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; reg_write_in = 1'b1;
        funct3 = 3'b011; rd_in = 5'd9; alu_result = 64'h4000; store_data = '0;
        @(negedge clk);
        chk("rst_stall_issue", {63'd0, stall}, 64'd1);
        @(posedge clk); #1;
        valid_in = 1'b0; mem_read = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst_req_before", {63'd0, dmem_req}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_after", {63'd0, dmem_req}, 64'd0);
        chk("rst_stall_after", {63'd0, stall}, 64'd0);
        exp_valid = 1'b0; exp_fault = 1'b0; exp_wb = '0; exp_regw = 1'b0; exp_rd = '0;
        check_outs();
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write_in = 1'b0;
        funct3 = '0; rd_in = '0; alu_result = '0; store_data = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        exp_valid = 1'b0; exp_fault = 1'b0; exp_wb = '0; exp_regw = 1'b0; exp_rd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs();
        chk("reset_req", {63'd0, dmem_req}, 64'd0);
        chk("reset_stall", {63'd0, stall}, 64'd0);
        chk("reset_addr", dmem_addr, 64'd0);
        chk("reset_wstrb", {56'd0, dmem_wstrb}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_op(1, 0, 0, 1, 3'b000, 5'd5, 64'h1234, 64'd0, 0, 64'd0, 1'b0);
        do_op(1, 1, 0, 1, 3'b000, 5'd7, 64'h1003, 64'd0, 0, 64'h0000_0000_80FF_0000, 1'b0);
        do_op(1, 1, 0, 1, 3'b100, 5'd7, 64'h1003, 64'd0, 1, 64'h0000_0000_80FF_0000, 1'b0);
        do_op(1, 0, 1, 1, 3'b001, 5'd3, 64'h2006, 64'hBEEF, 3, 64'd0, 1'b0);
        do_op(1, 1, 0, 1, 3'b010, 5'd4, 64'h3002, 64'd0, 0, 64'd0, 1'b0);
        do_op(1, 1, 1, 1, 3'b010, 5'd4, 64'h3002, 64'd0, 0, 64'd0, 1'b0);
        do_op(0, 0, 0, 0, 3'b000, 5'd0, 64'd0, 64'd0, 0, 64'd0, 1'b1);
        do_op(0, 0, 0, 0, 3'b000, 5'd0, 64'd0, 64'd0, 0, 64'd0, 1'b0);
        reset_mid_access();
        do_op(1, 1, 0, 1, 3'b011, 5'd10, 64'h4000, 64'd0, 0, 64'h0123_4567_89AB_CDEF, 1'b0);
        do_op(1, 1, 0, 1, 3'b011, 5'd11, 64'h4008, 64'd0, 0, 64'hFEDC_BA98_7654_3210, 1'b0);

        for (int i = 0; i < 400; i++) begin
            int sel;
            logic vin, rdq, wrq;
            logic [63:0] alu;
            sel = $urandom_range(0, 9);
            vin = (sel != 0);
            rdq = 1'b0; wrq = 1'b0;
            if (sel == 1) begin rdq = 1'b1; wrq = 1'b1; end
            else if (sel >= 4) begin
                rdq = $urandom_range(0, 1);
                wrq = ~rdq;
            end
            alu = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) alu[2:0] = 3'b000;
            do_op(vin, rdq, wrq, 1'($urandom), 3'($urandom), 5'($urandom), alu,
                  {$urandom, $urandom}, $urandom_range(0, 3), {$urandom, $urandom},
                  1'($urandom));
        end
        do_op(0, 0, 0, 0, 3'b000, 5'd0, 64'd0, 64'd0, 0, 64'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
